// File: rtl/ldpc_modulation_ram_writer.sv
// BPSK modulator: maps one codeword to 15-bit soft samples, written two per cycle
// into the dual-port sample RAM. Define LDPC_MOD_NOISE_EN to add LFSR noise.
module ldpc_modulation_ram_writer #(
  parameter int          CodeLen      = 256,
  parameter int          CodeLen_bits = 8,
  parameter int          AMP          = 4096,
  parameter int          NOISE_BITS   = 10,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    encoder_down,
  input  logic [CodeLen-1:0]      encoded_sequence,
  output logic                    modulation_receive,
  output logic                    wea,
  output logic [CodeLen_bits-1:0] addra,
  output logic [14:0]             dina,
  output logic                    web,
  output logic [CodeLen_bits-1:0] addrb,
  output logic [14:0]             dinb,
  output logic                    modulation_down,
  output logic [CodeLen-1:0]      modulation_sequence_before,
  input  logic                    demodulation_receive,
  input  logic                    demodulation_down_to_modulation,
  output logic                    demodulation_down_to_modulation_receive
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, NOTIFY = 2'd2, WAIT_DONE = 2'd3} state_t;

  localparam logic signed [15:0]      AMP16    = 16'(AMP);
  localparam logic [CodeLen_bits-1:0] LAST_IDX = CodeLen_bits'(CodeLen - 2);

  state_t                  state, state_nxt;
  logic [CodeLen_bits-1:0] idx;
  logic                    latch_en, recv_nxt, wr_nxt, down_nxt, ack_nxt;
  logic                    bit_a, bit_b;
  logic signed [14:0]      samp_a, samp_b;

  function automatic logic signed [15:0] bpsk(input logic b);
    return b ? -AMP16 : AMP16;
  endfunction

  function automatic logic signed [14:0] sat15(input logic signed [15:0] v);
    if (v > 16'sd16383)
      return 15'sd16383;
    else if (v < -16'sd16383)
      return -15'sd16383;
    else
      return v[14:0];
  endfunction

  assign bit_a = modulation_sequence_before[idx];
  assign bit_b = modulation_sequence_before[{idx[CodeLen_bits-1:1], 1'b1}];

`ifdef LDPC_MOD_NOISE_EN
  localparam logic [15:0] TAPS = 16'hB400;
  logic [15:0] lfsr_a, lfsr_b;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic signed [15:0] noise(input logic [15:0] s);
    return {{(16-NOISE_BITS){s[NOISE_BITS-1]}}, s[NOISE_BITS-1:0]};
  endfunction

  // LFSRs only step while samples are being produced
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_a <= SEED;
      lfsr_b <= SEED ^ 16'h5A5A;
    end else if (state == WRITE) begin
      lfsr_a <= lfsr_step(lfsr_a);
      lfsr_b <= lfsr_step(lfsr_b);
    end
  end

  assign samp_a = sat15(bpsk(bit_a) + noise(lfsr_a));
  assign samp_b = sat15(bpsk(bit_b) + noise(lfsr_b));
`else
  assign samp_a = sat15(bpsk(bit_a));
  assign samp_b = sat15(bpsk(bit_b));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (encoder_down) state_nxt = WRITE;
      WRITE:     if (idx == LAST_IDX) state_nxt = NOTIFY;
      NOTIFY:    if (modulation_down && demodulation_receive) state_nxt = WAIT_DONE;
      WAIT_DONE: if (demodulation_down_to_modulation) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; done is only acked from WAIT_DONE
  always_comb begin
    latch_en = (state == IDLE) && encoder_down;
    recv_nxt = latch_en;
    wr_nxt   = (state == WRITE);
    down_nxt = (state == NOTIFY) && !(modulation_down && demodulation_receive);
    ack_nxt  = (state == WAIT_DONE) && demodulation_down_to_modulation;
  end

  // p0: registered RAM write port and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modulation_receive                      <= 1'b0;
      wea                                     <= 1'b0;
      web                                     <= 1'b0;
      modulation_down                         <= 1'b0;
      demodulation_down_to_modulation_receive <= 1'b0;
      addra                                   <= '0;
      addrb                                   <= '0;
      dina                                    <= '0;
      dinb                                    <= '0;
      modulation_sequence_before              <= '0;
      idx                                     <= '0;
    end else begin
      modulation_receive                      <= recv_nxt;
      wea                                     <= wr_nxt;
      web                                     <= wr_nxt;
      modulation_down                         <= down_nxt;
      demodulation_down_to_modulation_receive <= ack_nxt;
      if (latch_en) begin
        modulation_sequence_before <= encoded_sequence;
        idx                        <= '0;
      end else if (wr_nxt) begin
        addra <= idx;
        addrb <= {idx[CodeLen_bits-1:1], 1'b1};
        dina  <= samp_a;
        dinb  <= samp_b;
        idx   <= idx + CodeLen_bits'(2);
      end
    end
  end
endmodule
